// File: rtl/sv_interface_impl_vif_pkg.sv
// Shared types for the tblink target-side interface endpoint: method ids,
// endpoint lifecycle states and the registered response record.
package sv_interface_impl_vif_pkg;

   localparam int          RET_W      = 32;
   localparam logic [63:0] METHOD_INC = 64'd0;

   typedef enum logic [1:0] {
      ST_RST    = 2'd0,
      ST_DEFINE = 2'd1,
      ST_READY  = 2'd2,
      ST_FATAL  = 2'd3
   } state_e;

   typedef struct packed {
      logic             has_ret;
      logic [RET_W-1:0] ret;
      logic             err;
   } rsp_t;

endpackage

// File: rtl/sv_ifimpl_dispatch.sv
// Combinational method decode: turns one invocation into its response record
// and the inc trace it causes.
module sv_ifimpl_dispatch
   import sv_interface_impl_vif_pkg::*;
#(
   parameter int ID_W   = 64,
   parameter int DATA_W = 32
) (
   input  logic [ID_W-1:0]   method_id_i,
   input  logic [DATA_W-1:0] param_i,
   input  logic              blocking_i,
   output rsp_t              rsp_o,
   output logic              inc_fire_o,
   output logic [DATA_W-1:0] inc_arg_o
);

   // Method decode; blocking invokes always run inc(1) and return null.
   always_comb begin
      rsp_o      = '0;
      inc_fire_o = 1'b0;
      inc_arg_o  = '0;
      if (blocking_i) begin
         inc_fire_o = 1'b1;
         inc_arg_o  = DATA_W'(1);
      end else if (method_id_i == ID_W'(METHOD_INC)) begin
         rsp_o.has_ret = 1'b1;
         rsp_o.ret     = param_i + DATA_W'(1);
         inc_fire_o    = 1'b1;
         inc_arg_o     = param_i;
      end else begin
         rsp_o.err = 1'b1;
      end
   end

endmodule

// File: rtl/sv_interface_impl_vif.sv
// Target-side tblink interface endpoint: registers itself with the default
// endpoint, then serves method invocations through a single response register.
module sv_interface_impl_vif
   import sv_interface_impl_vif_pkg::*;
#(
   parameter int INST_ID = 0,
   parameter int ID_W    = 64,
   parameter int DATA_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ep_present,
   output logic              def_valid,
   output logic [7:0]        def_inst_id,
   input  logic              def_ack,
   output logic              fatal,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_blocking,
   input  logic [ID_W-1:0]   req_method_id,
   input  logic [DATA_W-1:0] req_param,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_has_ret,
   output logic [DATA_W-1:0] rsp_ret,
   output logic              rsp_err,
   output logic              inc_valid,
   output logic [DATA_W-1:0] inc_arg
);

   state_e            state_q, state_d;
   rsp_t              rsp_q, rsp_d, disp_rsp;
   logic              rsp_valid_q, rsp_valid_d;
   logic              inc_valid_q, inc_valid_d;
   logic [DATA_W-1:0] inc_arg_q, inc_arg_d;
   logic              def_valid_q, def_valid_d;
   logic [7:0]        def_inst_id_q, def_inst_id_d;
   logic              fatal_q, fatal_d;
   logic              disp_fire;
   logic [DATA_W-1:0] disp_arg;
   logic              accept;

   sv_ifimpl_dispatch #(
      .ID_W   (ID_W),
      .DATA_W (DATA_W)
   ) u_dispatch (
      .method_id_i (req_method_id),
      .param_i     (req_param),
      .blocking_i  (req_blocking),
      .rsp_o       (disp_rsp),
      .inc_fire_o  (disp_fire),
      .inc_arg_o   (disp_arg)
   );

   // A new request may enter in the same cycle the held response is consumed.
   assign req_ready = (state_q == ST_READY) && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;

   // Lifecycle FSM next state; ep_present only matters on leaving RST.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RST: begin
            if (ep_present) begin
               state_d = ST_DEFINE;
            end else begin
               state_d = ST_FATAL;
            end
         end
         ST_DEFINE: begin
            if (def_ack) begin
               state_d = ST_READY;
            end else begin
               state_d = ST_DEFINE;
            end
         end
         ST_READY: state_d = ST_READY;
         ST_FATAL: state_d = ST_FATAL;
         default:  state_d = ST_RST;
      endcase
   end

   // Response register, inc trace pulse and state-decoded status outputs.
   always_comb begin
      rsp_valid_d   = rsp_valid_q;
      rsp_d         = rsp_q;
      inc_valid_d   = 1'b0;
      inc_arg_d     = '0;
      def_valid_d   = (state_d == ST_DEFINE);
      def_inst_id_d = def_valid_d ? 8'(INST_ID) : 8'd0;
      fatal_d       = (state_d == ST_FATAL);
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_d       = disp_rsp;
         inc_valid_d = disp_fire;
         inc_arg_d   = disp_fire ? disp_arg : '0;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
         rsp_d       = '0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_RST;
         rsp_q         <= '0;
         rsp_valid_q   <= 1'b0;
         inc_valid_q   <= 1'b0;
         inc_arg_q     <= '0;
         def_valid_q   <= 1'b0;
         def_inst_id_q <= 8'd0;
         fatal_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         rsp_q         <= rsp_d;
         rsp_valid_q   <= rsp_valid_d;
         inc_valid_q   <= inc_valid_d;
         inc_arg_q     <= inc_arg_d;
         def_valid_q   <= def_valid_d;
         def_inst_id_q <= def_inst_id_d;
         fatal_q       <= fatal_d;
      end
   end

   assign def_valid   = def_valid_q;
   assign def_inst_id = def_inst_id_q;
   assign fatal       = fatal_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_has_ret = rsp_q.has_ret;
   assign rsp_ret     = rsp_q.ret;
   assign rsp_err     = rsp_q.err;
   assign inc_valid   = inc_valid_q;
   assign inc_arg     = inc_arg_q;

endmodule

// File: tb/tb_sv_interface_impl_vif.sv
// Self-checking bench for sv_interface_impl_vif: directed bring-up, reset and
// fatal scenarios plus randomized invocations scored against a behavioural model.
module tb_sv_interface_impl_vif;

   localparam int INST_ID = 8'h2C;

   logic        clock;
   logic        reset;
   logic        ep_present;
   logic        def_valid;
   logic [7:0]  def_inst_id;
   logic        def_ack;
   logic        fatal;
   logic        req_valid;
   logic        req_ready;
   logic        req_blocking;
   logic [63:0] req_method_id;
   logic [31:0] req_param;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_has_ret;
   logic [31:0] rsp_ret;
   logic        rsp_err;
   logic        inc_valid;
   logic [31:0] inc_arg;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit        has_ret;
      bit [31:0] ret;
      bit        err;
      bit        inc;
      bit [31:0] arg;
   } exp_t;

   bit   pend;
   exp_t cur;

   sv_interface_impl_vif #(
      .INST_ID (INST_ID),
      .ID_W    (64),
      .DATA_W  (32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .ep_present    (ep_present),
      .def_valid     (def_valid),
      .def_inst_id   (def_inst_id),
      .def_ack       (def_ack),
      .fatal         (fatal),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_blocking  (req_blocking),
      .req_method_id (req_method_id),
      .req_param     (req_param),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_has_ret   (rsp_has_ret),
      .rsp_ret       (rsp_ret),
      .rsp_err       (rsp_err),
      .inc_valid     (inc_valid),
      .inc_arg       (inc_arg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // What a single invocation should produce, straight from the method rules.
   function automatic exp_t model(input bit blk, input bit [63:0] id, input bit [31:0] p);
      exp_t e;
      int   s;
      e = '{default: 0};
      s = $signed(p);
      if (blk) begin
         e.inc = 1'b1;
         e.arg = 32'd1;
      end else if (id == 64'd0) begin
         e.has_ret = 1'b1;
         e.ret     = 32'(s + 1);
         e.inc     = 1'b1;
         e.arg     = p;
      end else begin
         e.err = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".def_valid"}, 64'(def_valid), 64'd0);
      chk({tag, ".def_inst_id"}, 64'(def_inst_id), 64'd0);
      chk({tag, ".fatal"}, 64'(fatal), 64'd0);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, ".rsp_has_ret"}, 64'(rsp_has_ret), 64'd0);
      chk({tag, ".rsp_ret"}, 64'(rsp_ret), 64'd0);
      chk({tag, ".rsp_err"}, 64'(rsp_err), 64'd0);
      chk({tag, ".inc_valid"}, 64'(inc_valid), 64'd0);
      chk({tag, ".inc_arg"}, 64'(inc_arg), 64'd0);
   endtask

   // One READY-state cycle: drive, check ready, clock, then score outputs.
   task automatic cycle(input string tag, input bit rv, input bit blk,
                        input bit [63:0] id, input bit [31:0] p, input bit rr);
      bit   exp_ready;
      bit   acc;
      exp_t nx;
      req_valid     = rv;
      req_blocking  = blk;
      req_method_id = id;
      req_param     = p;
      rsp_ready     = rr;
      #1;
      exp_ready = !pend || rr;
      chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
      acc = rv && exp_ready;
      nx  = model(blk, id, p);
      step();
      if (acc) begin
         pend = 1'b1;
         cur  = nx;
      end else if (rr) begin
         pend = 1'b0;
      end
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(pend));
      if (pend) begin
         chk({tag, ".rsp_has_ret"}, 64'(rsp_has_ret), 64'(cur.has_ret));
         chk({tag, ".rsp_ret"}, 64'(rsp_ret), 64'(cur.ret));
         chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(cur.err));
      end
      chk({tag, ".inc_valid"}, 64'(inc_valid), 64'(acc && nx.inc));
      if (acc && nx.inc) begin
         chk({tag, ".inc_arg"}, 64'(inc_arg), 64'(nx.arg));
      end
   endtask

   task automatic bring_up(input string tag);
      reset = 1'b0;
      step();
      chk({tag, ".def_valid"}, 64'(def_valid), 64'd1);
      chk({tag, ".def_inst_id"}, 64'(def_inst_id), 64'(INST_ID));
      chk({tag, ".req_ready"}, 64'(req_ready), 64'd0);
      step();
      chk({tag, ".def_valid_held"}, 64'(def_valid), 64'd1);
      def_ack = 1'b1;
      step();
      def_ack = 1'b0;
      chk({tag, ".def_done"}, 64'(def_valid), 64'd0);
      chk({tag, ".fatal"}, 64'(fatal), 64'd0);
      pend = 1'b0;
   endtask

   initial begin
      bit [63:0] rid;
      reset         = 1'b1;
      ep_present    = 1'b1;
      def_ack       = 1'b0;
      req_valid     = 1'b0;
      req_blocking  = 1'b0;
      req_method_id = 64'd0;
      req_param     = 32'd0;
      rsp_ready     = 1'b0;
      pend          = 1'b0;
      cur           = '{default: 0};
      repeat (3) step();
      chk_zero("reset");

      bring_up("bringup");

      cycle("inc5", 1'b1, 1'b0, 64'd0, 32'd5, 1'b1);
      cycle("inc_m1", 1'b1, 1'b0, 64'd0, 32'hFFFF_FFFF, 1'b1);
      cycle("inc_max", 1'b1, 1'b0, 64'd0, 32'h7FFF_FFFF, 1'b1);
      cycle("id3", 1'b1, 1'b0, 64'd3, 32'd11, 1'b1);
      cycle("id_hi", 1'b1, 1'b0, 64'h1_0000_0000, 32'd12, 1'b1);
      cycle("blk42", 1'b1, 1'b1, 64'd0, 32'd42, 1'b1);
      cycle("drain", 1'b0, 1'b0, 64'd0, 32'd0, 1'b1);

      cycle("stall_req", 1'b1, 1'b0, 64'd0, 32'd100, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle("stall", 1'b1, 1'b0, 64'd0, 32'd200, 1'b0);
      end
      cycle("stall_release", 1'b1, 1'b0, 64'd0, 32'd200, 1'b1);

      for (int i = 0; i < 20; i++) begin
         cycle("stream", 1'b1, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 2)),
               $urandom, 1'b1);
      end

      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       rid = 64'd0;
            1:       rid = 64'h1_0000_0000;
            2:       rid = 64'd3;
            default: rid = {$urandom, $urandom};
         endcase
         cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), rid,
               $urandom, 1'($urandom_range(0, 1)));
      end

      cycle("mid_req", 1'b1, 1'b0, 64'd0, 32'd9, 1'b0);
      chk("mid_pending", 64'(rsp_valid), 64'd1);
      req_valid = 1'b0;
      reset     = 1'b1;
      step();
      chk_zero("mid_reset");
      bring_up("rebringup");
      cycle("after_reset", 1'b1, 1'b0, 64'd0, 32'd1, 1'b1);

      reset      = 1'b1;
      ep_present = 1'b0;
      req_valid  = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("fatal_set", 64'(fatal), 64'd1);
      chk("fatal_def", 64'(def_valid), 64'd0);
      ep_present = 1'b1;
      def_ack    = 1'b1;
      req_valid  = 1'b1;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("fatal_sticky", 64'(fatal), 64'd1);
         chk("fatal_req_ready", 64'(req_ready), 64'd0);
         chk("fatal_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("fatal_def_valid", 64'(def_valid), 64'd0);
         chk("fatal_inc", 64'(inc_valid), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sv_interface_impl_vif.md
# sv_interface_impl_vif

Hardware target-side endpoint of a tblink RPC BFM interface instance of type "target". After reset it registers one instance with the default endpoint, then accepts method invocations, dispatches them by method id, and returns responses. Method 0 ("inc") returns its 32-bit signed argument plus one. It sits between the RPC transport and the BFM, standing in for the core interface and its virtual-interface implementation object.

## Interface
Parameters:
- INST_ID, 0: instance id reported in the definition request.
- ID_W, 64: method-id width (longint).
- DATA_W, 32: integer parameter/return width.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ep_present  in  1  default endpoint exists.
- def_valid  out  1  instance-definition request.
- def_inst_id  out  8  equals INST_ID while def_valid.
- def_ack  in  1  endpoint accepted definition.
- fatal  out  1  sticky "no default endpoint" error.
- req_valid  in  1  invocation request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_blocking  in  1  1 = blocking invoke, 0 = non-blocking.
- req_method_id  in  ID_W  method id.
- req_param  in  DATA_W  parameter 0 (signed int).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_has_ret  out  1  response carries a return value (0 = null).
- rsp_ret  out  DATA_W  return value.
- rsp_err  out  1  unknown method id.
- inc_valid  out  1  one-cycle trace pulse: inc executed.
- inc_arg  out  DATA_W  argument of executed inc.

## Operation
- States: RST, DEFINE, READY, FATAL. reset forces RST.
- RST -> (first cycle with reset low) DEFINE if ep_present, else FATAL.
- DEFINE: def_valid=1 held until def_ack; on def_ack -> READY.
- FATAL: fatal=1, req_ready=0; left only by reset.
- READY: requests accepted; req_ready = !rsp_valid || rsp_ready.
- Non-blocking, method_id==0: rsp_has_ret=1, rsp_ret=req_param+1 mod 2^32, rsp_err=0; inc_valid pulse with inc_arg=req_param.
- Non-blocking, any other id: rsp_err=1, rsp_has_ret=0, rsp_ret=0; no inc pulse.
- Blocking, any method id: executes inc(1), so inc_valid pulses with inc_arg=1. Response is rsp_has_ret=0, rsp_ret=0, rsp_err=0.
- Wrap: 0x7FFFFFFF -> 0x80000000; 0xFFFFFFFF -> 0x00000000.
- Full method id compared (all ID_W bits); 0x1_0000_0000 is unknown.

## Timing
- Reset values: every output 0, state RST.
- Definition: def_valid rises in the cycle after reset deasserts; READY takes effect the cycle after def_ack.
- Request latency is 1: the response is registered and rsp_valid rises the cycle after acceptance. inc_valid pulses in that same cycle.
- The response and its fields are held stable until rsp_ready.
- Back-to-back: a new request is accepted in the cycle rsp_ready consumes the old response. That request's response appears the next cycle with no bubble.
- The single-entry response register never drops or overwrites an unconsumed response.
- def_ack outside DEFINE is ignored. ep_present is sampled only in RST.
- Reset mid-operation discards any pending response and restarts the definition.

## Structure
- Package sv_interface_impl_vif_pkg holds:
  - the METHOD_INC=0 constant;
  - the state enum;
  - the response struct (has_ret, ret, err).
- Sub-module sv_ifimpl_dispatch: combinational method decode. Inputs: method_id, param, blocking. Outputs: response struct, inc fire, inc arg.
- The top holds the FSM, handshakes and the response register.

## Test plan
- Bring-up with ep_present=1 and def_ack 2 cycles after def_valid -> def_inst_id=INST_ID, then READY. With ep_present=0 -> fatal=1 sticky, req_ready=0.
- Non-blocking id 0, param 5 -> next cycle rsp_has_ret=1, rsp_ret=6, rsp_err=0; inc_valid with inc_arg=5. Param -1 -> rsp_ret=0. Param 0x7FFFFFFF -> rsp_ret 0x80000000.
- Non-blocking ids 3 and 0x1_0000_0000 -> rsp_err=1, rsp_has_ret=0, no inc_valid.
- Blocking id 0, param 42 -> rsp_has_ret=0, rsp_err=0; inc_valid with inc_arg=1.
- rsp_ready held low 4 cycles -> response stable, req_ready=0. Continuous requests with rsp_ready=1 -> one response per cycle.
- Reset asserted while rsp_valid=1 -> all outputs 0 next cycle and the definition handshake repeats.
